// File: rtl/inst_fetch.sv
// Instruction fetch front end: issues PC reads to instruction memory on a credit basis and
// buffers returned words in an in-order FIFO. Flush discards buffered and in-flight fetches.
module inst_fetch #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] fifo_count;
  logic [PTR_W-1:0] tag_wr;
  logic [PTR_W-1:0] tag_rd;
  logic [PTR_W-1:0] fifo_wr;
  logic [PTR_W-1:0] fifo_rd;

  logic [31:0] tag_mem   [DEPTH];
  logic [31:0] fifo_pc   [DEPTH];
  logic [31:0] fifo_word [DEPTH];

  logic accept;
  logic resp;
  logic push;
  logic pop;

  // Credits cover both buffered words and requests still in flight, so the FIFO cannot overflow.
  assign pc_ready  = rst & ~flush & (({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_C);
  assign accept    = pc_valid & pc_ready;
  assign imem_req  = accept;
  assign imem_addr = accept ? pc_in : 32'd0;

  assign resp = imem_rvalid & (outstanding != '0);
  assign push = rst & resp & ~flush & (drop_cnt == '0);

  assign inst_valid = rst & (fifo_count != '0);
  assign inst_out   = inst_valid ? fifo_word[fifo_rd] : 32'd0;
  assign inst_pc    = inst_valid ? fifo_pc[fifo_rd] : 32'd0;
  assign pop        = inst_valid & inst_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
    end else begin
      case ({accept, resp})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
      if (accept) tag_wr <= tag_wr + PTR_W'(1);
      if (resp)   tag_rd <= tag_rd + PTR_W'(1);

      if (flush) begin
        // Everything still in flight after this edge must be dropped on return.
        drop_cnt   <= resp ? (outstanding - CNT_W'(1)) : outstanding;
        fifo_count <= '0;
        fifo_wr    <= '0;
        fifo_rd    <= '0;
      end else begin
        if (resp && drop_cnt != '0) drop_cnt <= drop_cnt - CNT_W'(1);
        if (push) fifo_wr <= fifo_wr + PTR_W'(1);
        if (pop)  fifo_rd <= fifo_rd + PTR_W'(1);
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + CNT_W'(1);
          2'b01:   fifo_count <= fifo_count - CNT_W'(1);
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers and counts above.
  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr] <= pc_in;
    if (push) begin
      fifo_pc[fifo_wr]   <= tag_mem[tag_rd];
      fifo_word[fifo_wr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: expected instructions are queued at stimulus time and a
// monitor compares them whenever decode consumes an instruction.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  inst_fetch #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_inst(input logic [31:0] pc, input logic [31:0] w);
    exp_q.push_back('{pc, w});
  endtask

  // Monitor: every consumed instruction must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && !flush && inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_inst: got pc=%h word=%h required none", inst_pc, inst_out);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e.pc);
          check("inst_out", inst_out, e.word);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; pc_valid = 1'b1; pc_in = 32'h1234; flush = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b1;
    tick(); tick();
    check("rst_pc_ready", 32'(pc_ready), 0);
    check("rst_imem_req", 32'(imem_req), 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_inst_valid", 32'(inst_valid), 0);
    check("rst_inst_out", inst_out, 0);
    check("rst_inst_pc", inst_pc, 0);
    rst = 1'b1; pc_valid = 1'b0;
    #1;
    check("post_rst_inst_valid", 32'(inst_valid), 0);
    check("post_rst_imem_req", 32'(imem_req), 0);
    check("post_rst_pc_ready", 32'(pc_ready), 1);

    // Single fetch
    pc_in = 32'h100; pc_valid = 1'b1;
    #1;
    check("single_imem_req", 32'(imem_req), 1);
    check("single_imem_addr", imem_addr, 32'h100);
    tick();
    pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2002000A;
    expect_inst(32'h100, 32'h2002000A);
    #1;
    check("single_no_bypass", 32'(inst_valid), 0);
    check("idle_imem_addr", imem_addr, 0);
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("single_latency", 32'(inst_valid), 1);
    tick();
    check("single_popped", 32'(inst_valid), 0);

    // Backpressure and ordering
    inst_ready = 1'b0; pc_in = 32'h0; pc_valid = 1'b1;
    tick();
    pc_in = 32'h4; imem_rvalid = 1'b1; imem_rdata = 32'h00000013;
    expect_inst(32'h0, 32'h00000013);
    #1;
    check("bp_second_accept", 32'(pc_ready), 1);
    tick();
    pc_valid = 1'b0; imem_rdata = 32'h00100093;
    expect_inst(32'h4, 32'h00100093);
    #1;
    check("bp_credit_out", 32'(pc_ready), 0);
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("bp_full_pc_ready", 32'(pc_ready), 0);
    check("bp_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1;
    check("bp_after_pop_ready", 32'(pc_ready), 1);
    check("bp_second_head", inst_pc, 32'h4);
    inst_ready = 1'b1;
    tick();
    check("bp_drained", 32'(inst_valid), 0);

    // Flush with two fetches in flight
    pc_in = 32'h8; pc_valid = 1'b1;
    tick();
    pc_in = 32'hC;
    tick();
    pc_in = 32'h99; flush = 1'b1;
    #1;
    check("flush_no_accept", 32'(imem_req), 0);
    tick();
    flush = 1'b0; pc_valid = 1'b0;
    #1;
    check("flush_credit_held", 32'(pc_ready), 0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD0001;
    tick();
    imem_rdata = 32'hDEAD0002;
    #1;
    check("flush_drop1", 32'(inst_valid), 0);
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("flush_drop2", 32'(inst_valid), 0);
    check("flush_ready_back", 32'(pc_ready), 1);
    pc_in = 32'h40; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00000033;
    expect_inst(32'h40, 32'h00000033);
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("flush_new_valid", 32'(inst_valid), 1);
    tick();

    // Flush with one buffered, one in flight returning in the flush cycle; flush beats pop
    inst_ready = 1'b0; pc_in = 32'h20; pc_valid = 1'b1;
    tick();
    pc_in = 32'h24; imem_rvalid = 1'b1; imem_rdata = 32'h11111111;
    tick();
    pc_valid = 1'b0; flush = 1'b1; imem_rdata = 32'h22222222; inst_ready = 1'b1;
    #1;
    check("fb_buffered", 32'(inst_valid), 1);
    tick();
    flush = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
    #1;
    check("fb_flush_priority", 32'(inst_valid), 0);
    check("fb_pc_ready", 32'(pc_ready), 1);
    pc_in = 32'h30; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h30303030;
    expect_inst(32'h30, 32'h30303030);
    tick();
    imem_rvalid = 1'b0; inst_ready = 1'b1;
    #1;
    check("fb_no_drop_pending", 32'(inst_valid), 1);
    tick();

    // Simultaneous push/pop, full FIFO, stray response
    inst_ready = 1'b0; pc_in = 32'h50; pc_valid = 1'b1;
    tick();
    pc_in = 32'h54; imem_rvalid = 1'b1; imem_rdata = 32'hA0A0A0A0;
    expect_inst(32'h50, 32'hA0A0A0A0);
    tick();
    pc_valid = 1'b0; imem_rdata = 32'hA1A1A1A1; inst_ready = 1'b1;
    expect_inst(32'h54, 32'hA1A1A1A1);
    #1;
    check("sim_credit", 32'(pc_ready), 0);
    tick();
    imem_rvalid = 1'b0; inst_ready = 1'b0;
    #1;
    check("sim_ready", 32'(pc_ready), 1);
    check("sim_head", inst_pc, 32'h54);
    pc_in = 32'h58; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA2A2A2A2;
    expect_inst(32'h58, 32'hA2A2A2A2);
    tick();
    imem_rdata = 32'hBADBAD00;
    #1;
    check("sim_full", 32'(pc_ready), 0);
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("sim_stray_head", inst_pc, 32'h54);
    inst_ready = 1'b1;
    tick();
    tick();
    inst_ready = 1'b0;
    #1;
    check("sim_stray_ignored", 32'(inst_valid), 0);

    // Back-to-back flushes
    inst_ready = 1'b1; pc_in = 32'h80; pc_valid = 1'b1;
    tick();
    pc_in = 32'h84;
    tick();
    pc_valid = 1'b0; flush = 1'b1;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hCCCC0001;
    tick();
    flush = 1'b0; imem_rdata = 32'hCCCC0002;
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("b2b_dropped", 32'(inst_valid), 0);
    check("b2b_ready", 32'(pc_ready), 1);
    pc_in = 32'h90; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h90909090;
    expect_inst(32'h90, 32'h90909090);
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("b2b_delivered", 32'(inst_valid), 1);
    tick();

    // Reset with two fetches outstanding
    pc_in = 32'h60; pc_valid = 1'b1;
    tick();
    pc_in = 32'h64;
    tick();
    pc_in = 32'h68; rst = 1'b0;
    #1;
    check("mid_rst_pc_ready", 32'(pc_ready), 0);
    check("mid_rst_imem_req", 32'(imem_req), 0);
    check("mid_rst_imem_addr", imem_addr, 0);
    tick();
    rst = 1'b1; pc_valid = 1'b0;
    #1;
    check("mid_rst_inst_valid", 32'(inst_valid), 0);
    check("mid_rst_out_cleared", 32'(pc_ready), 1);
    imem_rvalid = 1'b1; imem_rdata = 32'h60606060;
    tick();
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("mid_rst_late_ignored", 32'(inst_valid), 0);
    pc_in = 32'h70; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h70707070;
    expect_inst(32'h70, 32'h70707070);
    tick();
    imem_rvalid = 1'b0;
    #1;
    check("mid_rst_recover", 32'(inst_valid), 1);
    repeat (3) tick();

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
